capture_readout_buffer: RTL and testbench

// Sink-side companion of the signal_processing chain: captures a programmed number of

---
 rtl/capture_readout_buffer.sv | 146 ++++++++++++++
 tb/tb_capture_readout_buffer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_readout_buffer.sv
// Captures a programmed number of stream samples into RAM after the chain is ready, then drains one word per host read.
// Latency: rd_data/rd_data_valid one cycle after an accepted rd_req. No backpressure: surplus or disabled samples are dropped.
module capture_readout_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              arm,
    input  logic [31:0]       n_samples,
    input  logic              ready_to_calculate,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              rd_underflow,
    output logic [ADDR_W:0]   words_captured,
    output logic              busy,
    output logic              processing_done
);

    typedef enum logic [1:0] {IDLE, WAIT_READY, CAPTURE, DONE} state_t;

    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   target;
    logic [ADDR_W:0]   n_clamped;
    logic              arm_take;
    logic              wr_en;
    logic              wr_last;
    logic              rd_en;
    logic              rd_last;

    // A zero or oversized request means "fill the whole buffer".
    always_comb begin
        n_clamped = CNT_FULL;
        if (n_samples != 32'd0 && n_samples <= 32'(DEPTH)) begin
            n_clamped = n_samples[ADDR_W:0];
        end
    end

    assign arm_take = arm && (state == IDLE || state == DONE);
    assign wr_en    = (state == CAPTURE) && data_in_valid && enable;
    assign wr_last  = wr_en && ((words_captured + CNT_ONE) == target);
    assign rd_en    = (state == DONE) && rd_req && !arm && (rd_ptr < words_captured);
    assign rd_last  = rd_en && (rd_ptr == (target - CNT_ONE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            target          <= '0;
            words_captured  <= '0;
            rd_data_valid   <= 1'b0;
            rd_underflow    <= 1'b0;
            busy            <= 1'b0;
            processing_done <= 1'b0;
        end else begin
            rd_data_valid <= rd_en;

            // arm takes priority over a same-cycle read, so it never flags underflow
            if (arm_take) begin
                rd_underflow <= 1'b0;
            end else if (rd_req && !rd_en) begin
                rd_underflow <= 1'b1;
            end

            if (arm_take) begin
                target         <= n_clamped;
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                words_captured <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr         <= wr_ptr + ADDR_W'(1);
                    words_captured <= words_captured + CNT_ONE;
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + CNT_ONE;
                end
            end

            case (state)
                IDLE: begin
                    if (arm_take) begin
                        state <= WAIT_READY;
                        busy  <= 1'b1;
                    end
                end
                WAIT_READY: begin
                    // The cycle ready rises is a pure transition; its sample is not taken.
                    if (ready_to_calculate) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (wr_last) begin
                        state           <= DONE;
                        busy            <= 1'b0;
                        processing_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (arm_take) begin
                        state           <= WAIT_READY;
                        busy            <= 1'b1;
                        processing_done <= 1'b0;
                    end else if (rd_last) begin
                        state           <= IDLE;
                        processing_done <= 1'b0;
                    end
                end
                default: begin
                    state           <= IDLE;
                    busy            <= 1'b0;
                    processing_done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // rd_data holds its last value between accepted reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

endmodule

// File: tb/tb_capture_readout_buffer.sv
// Self-checking bench for capture_readout_buffer with a queue/array-based reference model.
module tb_capture_readout_buffer;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic              arm = 1'b0;
    logic [31:0]       n_samples = '0;
    logic              ready_to_calculate = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              data_in_valid = 1'b0;
    logic              rd_req = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              rd_underflow;
    logic [ADDR_W:0]   words_captured;
    logic              busy;
    logic              processing_done;

    int n_cmp = 0;
    int n_bad = 0;

    capture_readout_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .arm(arm), .n_samples(n_samples),
        .ready_to_calculate(ready_to_calculate), .data_in(data_in), .data_in_valid(data_in_valid),
        .rd_req(rd_req), .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_underflow(rd_underflow),
        .words_captured(words_captured), .busy(busy), .processing_done(processing_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Reference model: a capture session with a target count, a stored-sample array and a read count.
    bit          m_armed, m_waiting;
    int          m_target, m_cnt, m_rd;
    logic [31:0] m_mem [DEPTH];
    bit          e_rdv, e_under;
    logic [31:0] e_rdd;

    function automatic bit m_done();
        return m_armed && !m_waiting && (m_cnt == m_target);
    endfunction

    function automatic bit e_busy();
        return m_armed && !m_done();
    endfunction

    task automatic model_reset();
        m_armed = 0; m_waiting = 0; m_target = 0; m_cnt = 0; m_rd = 0;
        e_rdv = 0; e_under = 0; e_rdd = '0;
    endtask

    task automatic model_cycle();
        bit done_now;
        done_now = m_done();
        e_rdv = 0;
        if (arm && (!m_armed || done_now)) begin
            m_target  = (n_samples == 0 || n_samples > DEPTH) ? DEPTH : int'(n_samples);
            m_cnt     = 0;
            m_rd      = 0;
            e_under   = 0;
            m_armed   = 1;
            m_waiting = 1;
        end else if (done_now) begin
            if (rd_req && m_rd < m_cnt) begin
                e_rdv = 1;
                e_rdd = m_mem[m_rd];
                m_rd++;
                if (m_rd == m_target) m_armed = 0;
            end else if (rd_req) begin
                e_under = 1;
            end
        end else begin
            if (m_armed && m_waiting) begin
                if (ready_to_calculate) m_waiting = 0;
            end else if (m_armed) begin
                if (data_in_valid && enable) begin
                    m_mem[m_cnt] = data_in;
                    m_cnt++;
                end
            end
            if (rd_req) e_under = 1;
        end
    endtask

    task automatic tick();
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [31:0] n);
        n_samples = n;
        arm = 1;
        tick();
        arm = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_cmp++; if (rd_data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_data_valid); end
        n_cmp++; if (rd_underflow !== 1'b0) begin n_bad++; $display("FAIL reset_underflow: got %b want 0", rd_underflow); end
        n_cmp++; if (words_captured !== '0) begin n_bad++; $display("FAIL reset_words: got %0d want 0", words_captured); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (processing_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", processing_done); end
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_capture_read();
        enable = 1;
        do_arm(32'd8);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_after_arm: got %b want 1", busy); end
        ready_to_calculate = 1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            data_in = 32'(i);
            data_in_valid = 1;
            tick();
            n_cmp++;
            if (processing_done !== (i == 8)) begin
                n_bad++; $display("FAIL basic_done_write%0d: got %b want %b", i, processing_done, (i == 8));
            end
        end
        data_in_valid = 0;
        n_cmp++; if (words_captured !== 11'd8) begin n_bad++; $display("FAIL basic_words: got %0d want 8", words_captured); end
        rd_req = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_cmp++;
            if (rd_data_valid !== 1'b1 || rd_data !== 32'(i)) begin
                n_bad++; $display("FAIL basic_read%0d: got v=%b d=%0d want v=1 d=%0d", i, rd_data_valid, rd_data, i);
            end
            n_cmp++;
            if (processing_done !== (i < 8)) begin
                n_bad++; $display("FAIL basic_done_read%0d: got %b want %b", i, processing_done, (i < 8));
            end
        end
        rd_req = 0;
        tick();
        n_cmp++;
        if (rd_data_valid !== 1'b0 || rd_data !== 32'd8 || rd_underflow !== 1'b0) begin
            n_bad++; $display("FAIL basic_after_drain: got v=%b d=%0d uf=%b want v=0 d=8 uf=0", rd_data_valid, rd_data, rd_underflow);
        end
    endtask

    task automatic test_full_depth();
        do_arm(32'd0);
        ready_to_calculate = 1;
        enable = 1;
        data_in_valid = 1;
        data_in = $urandom;
        tick();
        for (int i = 0; i < 1030; i++) begin
            data_in = $urandom;
            tick();
        end
        data_in_valid = 0;
        n_cmp++; if (words_captured !== 11'(DEPTH)) begin n_bad++; $display("FAIL full_words: got %0d want %0d", words_captured, DEPTH); end
        n_cmp++; if (processing_done !== 1'b1) begin n_bad++; $display("FAIL full_done: got %b want 1", processing_done); end
        rd_req = 1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            n_cmp++;
            if (rd_data_valid !== e_rdv || rd_data !== e_rdd) begin
                n_bad++; $display("FAIL full_read%0d: got v=%b d=%h want v=%b d=%h", i, rd_data_valid, rd_data, e_rdv, e_rdd);
            end
        end
        rd_req = 0;
        tick();
        n_cmp++;
        if (processing_done !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL full_idle: got done=%b busy=%b want 0 0", processing_done, busy);
        end
    endtask

    task automatic test_gating();
        do_arm(32'd4);
        ready_to_calculate = 0;
        enable = 1;
        data_in_valid = 1;
        repeat (5) begin
            data_in = $urandom;
            tick();
        end
        n_cmp++;
        if (words_captured !== 11'd0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL gate_not_ready: got words=%0d busy=%b want 0 1", words_captured, busy);
        end
        ready_to_calculate = 1;
        data_in = $urandom;
        tick();
        enable = 0;
        data_in = $urandom;
        tick();
        n_cmp++;
        if (words_captured !== 11'd0) begin
            n_bad++; $display("FAIL gate_transition_and_disabled: got %0d want 0", words_captured);
        end
        for (int i = 0; i < 200 && !m_done(); i++) begin
            data_in_valid = 1'($urandom_range(0, 1));
            enable = 1'($urandom_range(0, 1));
            data_in = $urandom;
            tick();
            n_cmp++;
            if (words_captured !== 11'(m_cnt) || busy !== e_busy()) begin
                n_bad++; $display("FAIL gate_cycle%0d: got words=%0d busy=%b want %0d %b", i, words_captured, busy, m_cnt, e_busy());
            end
        end
        data_in_valid = 0;
        enable = 1;
        n_cmp++;
        if (processing_done !== 1'b1 || words_captured !== 11'd4) begin
            n_bad++; $display("FAIL gate_done: got done=%b words=%0d want 1 4", processing_done, words_captured);
        end
        rd_req = 1;
        repeat (4) begin
            tick();
            n_cmp++;
            if (rd_data_valid !== e_rdv || rd_data !== e_rdd) begin
                n_bad++; $display("FAIL gate_read: got v=%b d=%h want v=%b d=%h", rd_data_valid, rd_data, e_rdv, e_rdd);
            end
        end
        rd_req = 0;
        tick();
    endtask

    task automatic test_underflow();
        rd_req = 1;
        tick();
        rd_req = 0;
        n_cmp++;
        if (rd_data_valid !== 1'b0 || rd_underflow !== 1'b1 || rd_data !== e_rdd) begin
            n_bad++; $display("FAIL uf_idle: got v=%b uf=%b d=%h want v=0 uf=1 d=%h", rd_data_valid, rd_underflow, rd_data, e_rdd);
        end
        do_arm(32'd4);
        n_cmp++; if (rd_underflow !== 1'b0) begin n_bad++; $display("FAIL uf_arm_clear: got %b want 0", rd_underflow); end
        ready_to_calculate = 1;
        tick();
        data_in_valid = 1;
        repeat (4) begin
            data_in = $urandom;
            tick();
        end
        data_in_valid = 0;
        rd_req = 1;
        repeat (4) begin
            tick();
            n_cmp++;
            if (rd_data_valid !== e_rdv || rd_data !== e_rdd) begin
                n_bad++; $display("FAIL uf_read: got v=%b d=%h want v=%b d=%h", rd_data_valid, rd_data, e_rdv, e_rdd);
            end
        end
        tick();
        rd_req = 0;
        n_cmp++;
        if (rd_data_valid !== 1'b0 || rd_underflow !== 1'b1 || rd_underflow !== e_under) begin
            n_bad++; $display("FAIL uf_fifth_read: got v=%b uf=%b want v=0 uf=1", rd_data_valid, rd_underflow);
        end
        do_arm(32'd4);
        n_cmp++;
        if (rd_underflow !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL uf_rearm: got uf=%b busy=%b want 0 1", rd_underflow, busy);
        end
    endtask

    task automatic test_arm_in_done();
        ready_to_calculate = 1;
        tick();
        data_in_valid = 1;
        repeat (4) begin
            data_in = $urandom;
            tick();
        end
        data_in_valid = 0;
        n_cmp++; if (processing_done !== 1'b1) begin n_bad++; $display("FAIL rearm_done: got %b want 1", processing_done); end
        rd_req = 1;
        repeat (2) begin
            tick();
            n_cmp++;
            if (rd_data_valid !== e_rdv || rd_data !== e_rdd) begin
                n_bad++; $display("FAIL rearm_partial_read: got v=%b d=%h want v=%b d=%h", rd_data_valid, rd_data, e_rdv, e_rdd);
            end
        end
        do_arm(32'd4);
        rd_req = 0;
        n_cmp++;
        if (rd_data_valid !== 1'b0 || rd_underflow !== 1'b0 || words_captured !== 11'd0 || busy !== 1'b1 || processing_done !== 1'b0) begin
            n_bad++; $display("FAIL rearm_state: got v=%b uf=%b words=%0d busy=%b done=%b want 0 0 0 1 0",
                              rd_data_valid, rd_underflow, words_captured, busy, processing_done);
        end
        tick();
        data_in_valid = 1;
        repeat (4) begin
            data_in = $urandom;
            tick();
        end
        data_in_valid = 0;
        rd_req = 1;
        repeat (4) begin
            tick();
            n_cmp++;
            if (rd_data_valid !== e_rdv || rd_data !== e_rdd) begin
                n_bad++; $display("FAIL rearm_new_read: got v=%b d=%h want v=%b d=%h", rd_data_valid, rd_data, e_rdv, e_rdd);
            end
        end
        rd_req = 0;
        tick();
    endtask

    task automatic test_reset_mid_capture();
        do_arm(32'd8);
        ready_to_calculate = 1;
        tick();
        data_in_valid = 1;
        repeat (3) begin
            data_in = $urandom;
            tick();
        end
        data_in_valid = 0;
        n_cmp++; if (words_captured !== 11'd3) begin n_bad++; $display("FAIL midrst_pre_words: got %0d want 3", words_captured); end
        #2;
        reset_n = 0;
        model_reset();
        #1;
        n_cmp++;
        if (rd_data !== '0 || rd_data_valid !== 1'b0 || rd_underflow !== 1'b0 || words_captured !== '0 || busy !== 1'b0 || processing_done !== 1'b0) begin
            n_bad++; $display("FAIL midrst_async: got d=%h v=%b uf=%b words=%0d busy=%b done=%b want all 0",
                              rd_data, rd_data_valid, rd_underflow, words_captured, busy, processing_done);
        end
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
        data_in_valid = 1;
        repeat (4) begin
            data_in = $urandom;
            tick();
        end
        n_cmp++;
        if (busy !== 1'b0 || words_captured !== 11'd0) begin
            n_bad++; $display("FAIL midrst_needs_arm: got busy=%b words=%0d want 0 0", busy, words_captured);
        end
        do_arm(32'd2);
        repeat (3) begin
            data_in = $urandom;
            tick();
        end
        data_in_valid = 0;
        n_cmp++;
        if (processing_done !== 1'b1 || words_captured !== 11'(m_cnt)) begin
            n_bad++; $display("FAIL midrst_recapture: got done=%b words=%0d want 1 %0d", processing_done, words_captured, m_cnt);
        end
        rd_req = 1;
        repeat (2) begin
            tick();
            n_cmp++;
            if (rd_data_valid !== e_rdv || rd_data !== e_rdd) begin
                n_bad++; $display("FAIL midrst_read: got v=%b d=%h want v=%b d=%h", rd_data_valid, rd_data, e_rdv, e_rdd);
            end
        end
        rd_req = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_capture_read();
        test_full_depth();
        test_gating();
        test_underflow();
        test_arm_in_done();
        test_reset_mid_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
